// File: rtl/lpc_synth_if.sv
// Signal bundle between the LPC synthesis stage and its frame/sample source and DAC sink.
interface lpc_synth_if;
  logic signed [15:0] A1, A2, A3, A4, A5, A6, A7, A8, A9, A10;
  logic               voiced;
  logic        [15:0] freq_count;
  logic signed [15:0] gain;
  logic               load;
  logic               v;
  logic signed [15:0] y;
  logic               vout;
  logic               busy;

  modport slave (
    input  A1, A2, A3, A4, A5, A6, A7, A8, A9, A10,
    input  voiced, freq_count, gain, load, v,
    output y, vout, busy
  );

  modport master (
    output A1, A2, A3, A4, A5, A6, A7, A8, A9, A10,
    output voiced, freq_count, gain, load, v,
    input  y, vout, busy
  );
endinterface

// File: rtl/lpc_synth.sv
// LPC synthesis: pulse/noise excitation into a 10th-order all-pole IIR, one shared multiplier, 13 cycles per sample.
// Output saturation is enabled by defining LPC_SYNTH_SAT_EN; otherwise the result wraps to 16 bits.
module lpc_synth #(
  parameter int FRAC = 12
) (
  input  logic        clk,
  input  logic        rst,
  lpc_synth_if.slave  bus
);
  localparam int ORDER = 10;

  typedef enum logic [1:0] {IDLE, EXC, MAC, OUT} state_t;

  state_t             state;
  logic signed [15:0] in_a   [ORDER];
  logic signed [15:0] sh_a   [ORDER];
  logic signed [15:0] act_a  [ORDER];
  logic signed [15:0] hist   [ORDER];
  logic               sh_voiced, act_voiced;
  logic        [15:0] sh_freq, act_freq;
  logic signed [15:0] sh_gain, act_gain;
  logic signed [39:0] acc;
  logic        [3:0]  tap;
  logic        [15:0] pc;
  logic        [15:0] lfsr;
  logic               prev_voiced;
  logic signed [15:0] y_q;
  logic               vout_q;
  logic               busy_q;

  logic               voiced_eff;
  logic               pulse_now;
  logic signed [15:0] e;
  logic signed [39:0] e_ext;
  logic signed [31:0] prod;
  logic               lfsr_fb;
  logic signed [15:0] y_next;

  always_comb begin
    in_a[0] = bus.A1;
    in_a[1] = bus.A2;
    in_a[2] = bus.A3;
    in_a[3] = bus.A4;
    in_a[4] = bus.A5;
    in_a[5] = bus.A6;
    in_a[6] = bus.A7;
    in_a[7] = bus.A8;
    in_a[8] = bus.A9;
    in_a[9] = bus.A10;
  end

  // Voiced excitation needs a usable pitch period; anything shorter falls back to noise.
  always_comb begin
    voiced_eff = act_voiced && (act_freq >= 16'd2);
    pulse_now  = !prev_voiced || (pc == 16'd0);
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    e          = '0;
    if (voiced_eff) begin
      if (pulse_now) e = act_gain;
    end else begin
      e = lfsr[0] ? act_gain : -act_gain;
    end
    e_ext = 40'(e);
    prod  = 32'(act_a[tap]) * 32'(hist[tap]);
  end

`ifdef LPC_SYNTH_SAT_EN
  logic signed [39:0] r;
  always_comb begin
    r = acc >>> FRAC;
    if (r > 40'sd32767)       y_next = 16'sh7FFF;
    else if (r < -40'sd32768) y_next = 16'sh8000;
    else                      y_next = r[15:0];
  end
`else
  always_comb begin
    y_next = 16'(acc >>> FRAC);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      tap         <= '0;
      pc          <= '0;
      lfsr        <= 16'hACE1;
      prev_voiced <= 1'b0;
      sh_voiced   <= 1'b0;
      sh_freq     <= '0;
      sh_gain     <= '0;
      act_voiced  <= 1'b0;
      act_freq    <= '0;
      act_gain    <= '0;
      y_q         <= '0;
      vout_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        sh_a[i]  <= '0;
        act_a[i] <= '0;
        hist[i]  <= '0;
      end
    end else begin
      vout_q <= 1'b0;
      if (bus.load) begin
        sh_a      <= in_a;
        sh_voiced <= bus.voiced;
        sh_freq   <= bus.freq_count;
        sh_gain   <= bus.gain;
      end
      case (state)
        IDLE: begin
          if (bus.v) begin
            // A load arriving with the request bypasses the shadow bank.
            if (bus.load) begin
              act_a      <= in_a;
              act_voiced <= bus.voiced;
              act_freq   <= bus.freq_count;
              act_gain   <= bus.gain;
            end else begin
              act_a      <= sh_a;
              act_voiced <= sh_voiced;
              act_freq   <= sh_freq;
              act_gain   <= sh_gain;
            end
            busy_q <= 1'b1;
            state  <= EXC;
          end
        end
        EXC: begin
          acc <= e_ext <<< FRAC;
          if (voiced_eff) begin
            pc <= pulse_now ? (act_freq - 16'd1) : (pc - 16'd1);
          end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
          end
          prev_voiced <= voiced_eff;
          tap         <= '0;
          state       <= MAC;
        end
        MAC: begin
          acc <= acc - 40'(prod);
          tap <= tap + 4'd1;
          if (tap == 4'(ORDER - 1)) state <= OUT;
        end
        OUT: begin
          y_q     <= y_next;
          hist[0] <= y_next;
          for (int i = 1; i < ORDER; i++) hist[i] <= hist[i-1];
          vout_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.vout = vout_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_lpc_synth.sv
// Directed bench for lpc_synth: pulse train, single pole, overflow, noise, strobe handling, mid-sample reset.
module tb_lpc_synth;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lpc_synth_if bus ();
  lpc_synth dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] lfsr_m;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input logic signed [15:0] a1, input logic vcd,
                           input logic [15:0] fc, input logic signed [15:0] g);
    bus.A1 = a1; bus.A2 = 0; bus.A3 = 0; bus.A4 = 0; bus.A5 = 0;
    bus.A6 = 0;  bus.A7 = 0; bus.A8 = 0; bus.A9 = 0; bus.A10 = 0;
    bus.voiced = vcd; bus.freq_count = fc; bus.gain = g;
  endtask

  task automatic do_load();
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered and left on a falling edge; checks latency, busy and the sample value.
  task automatic sample(input string tag, input logic signed [15:0] exp_y);
    int lat;
    bit got;
    bus.v = 1'b1;
    @(negedge clk);
    bus.v = 1'b0;
    bus.load = 1'b0;
    lat = 0;
    got = 0;
    chk({tag, "_busy_hi"}, 32'(bus.busy), 1);
    while (!got && lat < 40) begin
      if (bus.vout) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_lat"}, got ? lat : -1, 12);
    chk({tag, "_y"}, bus.y, exp_y);
    chk({tag, "_busy_lo"}, 32'(bus.busy), 0);
  endtask

  initial begin : main
    int sp [11] = '{1000, 500, 250, 125, 62, 31, 15, 7, 3, 1, 0};
    int vcnt;
    int vlat;
    logic signed [15:0] vy;

    rst = 1'b1;
    bus.v = 1'b0;
    bus.load = 1'b0;
    set_frame(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_y", bus.y, 0);
    chk("rst_vout", 32'(bus.vout), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // Pulse train, period 4
    set_frame(0, 1, 4, 1000);
    do_load();
    for (int i = 0; i < 9; i++) sample($sformatf("pulse%0d", i), (i % 4 == 0) ? 16'sd1000 : 16'sd0);

    // Single pole at 0.5
    do_reset();
    set_frame(-2048, 1, 100, 1000);
    do_load();
    for (int i = 0; i < 11; i++) sample($sformatf("pole%0d", i), 16'(sp[i]));

    // Pole at 1.0 driving the output past full scale
    do_reset();
    set_frame(-4096, 1, 2, 20000);
    do_load();
    sample("ovf0", 16'sd20000);
    sample("ovf1", 16'sd20000);
`ifdef LPC_SYNTH_SAT_EN
    sample("ovf2", 16'sd32767);
`else
    sample("ovf2", -16'sd25536);
`endif

    // Noise excitation against a reference LFSR
    do_reset();
    set_frame(0, 0, 0, 500);
    do_load();
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 32; i++) begin
      sample($sformatf("noise%0d", i), lfsr_m[0] ? 16'sd500 : -16'sd500);
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Dropped second strobe and load while busy
    do_reset();
    set_frame(-2048, 1, 100, 1000);
    do_load();
    sample("strb0", 16'sd1000);
    bus.v = 1'b1;
    @(negedge clk);
    bus.v = 1'b0;
    vcnt = 0;
    vlat = -1;
    vy = 0;
    for (int lat = 0; lat < 30; lat++) begin
      if (lat == 2) begin
        set_frame(-4096, 1, 100, 1000);
        bus.load = 1'b1;
      end
      if (lat == 3) bus.load = 1'b0;
      if (lat == 4) bus.v = 1'b1;
      if (lat == 5) bus.v = 1'b0;
      if (bus.vout) begin
        vcnt++;
        vlat = lat;
        vy = bus.y;
      end
      @(negedge clk);
    end
    chk("strb_count", vcnt, 1);
    chk("strb_lat", vlat, 12);
    chk("strb_y_old_coef", vy, 500);
    sample("strb_next_new_coef", 16'sd500);
    set_frame(-2048, 1, 100, 1000);
    bus.load = 1'b1;
    sample("strb_bypass", 16'sd250);

    // Reset in the middle of the tap loop
    do_reset();
    set_frame(-2048, 1, 100, 1000);
    do_load();
    sample("rmid0", 16'sd1000);
    bus.v = 1'b1;
    @(negedge clk);
    bus.v = 1'b0;
    for (int lat = 0; lat < 5; lat++) begin
      if (lat == 3) chk("rmid_busy_before", 32'(bus.busy), 1);
      @(negedge clk);
    end
    do_reset();
    chk("rmid_y", bus.y, 0);
    chk("rmid_busy", 32'(bus.busy), 0);
    vcnt = 0;
    for (int lat = 0; lat < 20; lat++) begin
      if (bus.vout) vcnt++;
      @(negedge clk);
    end
    chk("rmid_no_vout", vcnt, 0);
    do_load();
    sample("rmid_fresh0", 16'sd1000);
    sample("rmid_fresh1", 16'sd500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
